online_otf_converter: RTL and testbench
=======================================

ONLINE_OTF_CONVERTER -- requirements
Module: online_otf_converter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the number of converted result digits per frame.
REQ-002 The block SHALL have parameter ONLINE_DELAY, default 4, the number of leading stream digits discarded per frame.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock; all state SHALL update only on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 The block SHALL have port en  input  1  digit qualifier; a digit is consumed only in cycles with en=1.
REQ-006 The block SHALL have port start  input  1  frame start; effective only when en=1.
REQ-007 The block SHALL have port d  input  signed_digit (rbr_pkg)  redundant digit, {plus,minus}: 10=+1, 01=-1, 00=0.
REQ-008 The block SHALL have port result  output  WIDTH+1  signed two's complement, value = result * 2^-(WIDTH-1).
REQ-009 The block SHALL have port valid  output  1  single-cycle pulse marking a completed frame.
REQ-010 The block SHALL have port busy  output  1  high while a frame is in progress (SKIP or CONV).
REQ-011 The block SHALL have port err  output  1  sticky invalid-digit flag (see Configuration).

Function
REQ-012 The FSM SHALL have states IDLE, SKIP, CONV, DONE.
REQ-013 A cycle with start=1 and en=1 SHALL be stream index 0 of a new frame, from any state, aborting any frame in progress and clearing err.
REQ-014 Stream indices 0..ONLINE_DELAY-1 SHALL be discarded (SKIP); indices ONLINE_DELAY..ONLINE_DELAY+WIDTH-1 SHALL be converted (CONV); ONLINE_DELAY=0 SHALL enter CONV directly.
REQ-015 Digit at index ONLINE_DELAY SHALL carry weight 2^0, each later digit half the previous weight.
REQ-016 Conversion SHALL use on-the-fly registers Q and QM (QM = Q - 1 ulp), initialised Q=0, QM=-1 at frame start.
REQ-017 Per converted digit: +1 -> Q={Q,1}, QM={Q,0}; 0 -> Q={Q,0}, QM={QM,1}; -1 -> Q={QM,1}, QM={QM,0} (left shift, WIDTH+1 bits, no carry chain).
REQ-018 Cycles with en=0 SHALL hold all state, counters and outputs, and SHALL not advance the stream index.
REQ-019 After the last converted digit the FSM SHALL enter DONE; valid SHALL be 1 for exactly that one cycle, result = Q.
REQ-020 From DONE the FSM SHALL return to IDLE next cycle, or to SKIP/CONV if start=1 and en=1 in the DONE cycle.
REQ-021 result SHALL hold the last completed frame value until the next valid pulse or reset; it SHALL not expose partial Q.
REQ-022 busy SHALL be 1 in SKIP and CONV, 0 in IDLE and DONE.
REQ-023 start=1 with en=0 SHALL be ignored.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE, counters 0, Q=0, QM=-1, result=0, valid=0, busy=0, err=0, overriding start and en, including mid-frame.

Configuration
REQ-025 Macro OTF_INVALID_DIGIT_EN defined: d=11 in any consumed digit cycle of a frame SHALL set err, held until next frame start or reset; the digit SHALL be converted as 0.
REQ-026 Macro OTF_INVALID_DIGIT_EN undefined: d=11 SHALL be converted as 0 and err SHALL be tied 0.

Verification
REQ-027 WIDTH=16, ONLINE_DELAY=4, en=1: start with indices 0-3 = 00, index 4 = +1, rest 00 -> valid at cycle 21 (start = cycle 0), result=17'h08000 (1.0).
REQ-028 Indices 4,5 = +1,-1, rest 0 -> result=17'h04000 (0.5); index 4 = -1, rest 0 -> result=17'h18000 (-1.0).
REQ-029 Same stream as REQ-027 with en=0 inserted for 3 cycles after index 6 -> valid 3 cycles later, result=17'h08000, busy high throughout.
REQ-030 start re-asserted at index 10 of a frame, new stream index 4 = -1 -> single valid, result=17'h18000, no valid for aborted frame.
REQ-031 rst asserted at index 8 -> next cycle valid=0, busy=0, result=0; no valid until a new start.
REQ-032 d=11 at index 6: macro defined -> err=1 until next start, result as for 00; macro undefined -> err=0.

Source files
------------

// File: rtl/online_otf_converter.sv
// Online-to-conventional converter for a redundant (signed-digit) stream.
// A frame starts on start&en. The first ONLINE_DELAY digits are dropped, and
// the next WIDTH digits are folded MSD-first into Q/QM on-the-fly registers.
// The frame result is registered and flagged with a one-cycle valid pulse.
// Optional feature macro: OTF_INVALID_DIGIT_EN. When it is defined, a digit
// of 11 inside a frame raises a sticky err. In both builds that digit
// converts as 0.
// Handshake: there is no backpressure. A digit is taken in every cycle with
// en=1, and en=0 freezes the whole block. valid means result holds a newly
// completed frame. result stays at that value until the next valid pulse.

package rbr_pkg;
  typedef struct packed {
    logic plus;
    logic minus;
  } signed_digit;
endpackage

module online_otf_converter
  import rbr_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int ONLINE_DELAY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  signed_digit      d,
  output logic [WIDTH:0]   result,
  output logic             valid,
  output logic             busy,
  output logic             err,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {IDLE, SKIP, CONV, DONE} state_t;

  localparam int IW = $clog2(ONLINE_DELAY + WIDTH + 1);
  localparam logic [IW-1:0] OD_L  = IW'(ONLINE_DELAY);
  localparam logic [IW-1:0] END_L = IW'(ONLINE_DELAY + WIDTH);

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [WIDTH:0]  q_q, q_d;
  logic [WIDTH:0]  qm_q, qm_d;
  logic [WIDTH:0]  result_q, result_d;
  logic            valid_q, valid_d;

  logic            new_frame;
  logic            active;
  logic [WIDTH:0]  base_q;
  logic [WIDTH:0]  base_qm;
  logic [IW-1:0]   cur_idx;

  // Next-state logic: a start restarts from a clean Q/QM. In that cycle the
  // start digit is stream index 0.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    q_d       = q_q;
    qm_d      = qm_q;
    result_d  = result_q;
    valid_d   = valid_q;
    new_frame = en && start;
    active    = new_frame || (en && ((state_q == SKIP) || (state_q == CONV)));
    base_q    = new_frame ? '0 : q_q;
    base_qm   = new_frame ? '1 : qm_q;
    cur_idx   = new_frame ? '0 : idx_q;

    if (en) begin
      valid_d = (state_q == DONE);
      if (state_q == DONE) begin
        result_d = q_q;
      end
    end

    if (active) begin
      idx_d = cur_idx + IW'(1);
      q_d   = base_q;
      qm_d  = base_qm;
      if (cur_idx >= OD_L) begin
        // Append one digit. The selection between Q and QM absorbs the borrow,
        // so no carry chain is needed.
        case ({d.plus, d.minus})
          2'b10: begin
            q_d  = {base_q[WIDTH-1:0], 1'b1};
            qm_d = {base_q[WIDTH-1:0], 1'b0};
          end
          2'b01: begin
            q_d  = {base_qm[WIDTH-1:0], 1'b1};
            qm_d = {base_qm[WIDTH-1:0], 1'b0};
          end
          default: begin
            q_d  = {base_q[WIDTH-1:0], 1'b0};
            qm_d = {base_qm[WIDTH-1:0], 1'b1};
          end
        endcase
      end
      if (idx_d < OD_L) begin
        state_d = SKIP;
      end else if (idx_d < END_L) begin
        state_d = CONV;
      end else begin
        state_d = DONE;
      end
    end else if (en && (state_q == DONE)) begin
      state_d = IDLE;
      idx_d   = '0;
    end
  end

  // State and datapath registers, with a synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      q_q      <= '0;
      qm_q     <= '1;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      q_q      <= q_d;
      qm_q     <= qm_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

`ifdef OTF_INVALID_DIGIT_EN
  logic err_q, err_d;

  // Sticky invalid-digit flag. A new frame clears it, unless that frame's
  // start digit is itself invalid.
  always_comb begin
    err_d = err_q;
    if (new_frame) begin
      err_d = d.plus & d.minus;
    end else if (active && d.plus && d.minus) begin
      err_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign result    = result_q;
  assign valid     = valid_q;
  assign busy      = (state_q == SKIP) || (state_q == CONV);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_online_otf_converter.sv
// Directed testbench for online_otf_converter (WIDTH=16, ONLINE_DELAY=4).
// Each task plays one scenario cycle by cycle and checks its outputs inline.
// Inputs change 1 time unit after a rising edge, and outputs are sampled there.

module tb_online_otf_converter;
  import rbr_pkg::*;

  localparam logic [1:0] Z = 2'b00;
  localparam logic [1:0] P = 2'b10;
  localparam logic [1:0] M = 2'b01;
  localparam logic [1:0] X = 2'b11;

  logic        clk;
  logic        rst;
  logic        en;
  logic        start;
  signed_digit d_s;
  logic [16:0] result;
  logic        valid;
  logic        busy;
  logic        err;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  online_otf_converter #(.WIDTH(16), .ONLINE_DELAY(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .start     (start),
    .d         (d_s),
    .result    (result),
    .valid     (valid),
    .busy      (busy),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: present one cycle of inputs, then sample just after the edge
  task automatic cyc(input logic r, input logic e, input logic s, input logic [1:0] dd);
    rst   = r;
    en    = e;
    start = s;
    d_s   = dd;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b1, 1'b1, P);
    cyc(1'b1, 1'b1, 1'b1, P);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (result !== 17'h00000) begin bad++; $display("FAIL reset_result: got %h want 00000", result); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    cyc(1'b0, 1'b1, 1'b0, Z);
  endtask

  // index 4 = +1, rest 0: expect 1.0, with valid in cycle 21
  task automatic test_plus_one();
    logic [1:0] dg;
    for (int k = 0; k < 24; k++) begin
      dg = (k == 4) ? P : Z;
      cyc(1'b0, 1'b1, k == 0, dg);
      total++; if (valid !== (k == 20)) begin bad++; $display("FAIL one_valid k=%0d: got %b want %b", k, valid, k == 20); end
      total++; if (busy !== (k < 19)) begin bad++; $display("FAIL one_busy k=%0d: got %b want %b", k, busy, k < 19); end
      if (k == 20) begin
        total++; if (result !== 17'h08000) begin bad++; $display("FAIL one_result: got %h want 08000", result); end
      end
    end
  endtask

  // +1,-1 at indices 4,5: expect 0.5, held after the valid pulse
  task automatic test_half();
    logic [1:0] dg;
    for (int k = 0; k < 27; k++) begin
      dg = (k == 4) ? P : ((k == 5) ? M : Z);
      cyc(1'b0, 1'b1, k == 0, dg);
      total++; if (valid !== (k == 20)) begin bad++; $display("FAIL half_valid k=%0d: got %b want %b", k, valid, k == 20); end
      if (k >= 20) begin
        total++; if (result !== 17'h04000) begin bad++; $display("FAIL half_result k=%0d: got %h want 04000", k, result); end
      end
    end
  endtask

  // -1 at index 4: expect -1.0
  task automatic test_minus_one();
    logic [1:0] dg;
    for (int k = 0; k < 23; k++) begin
      dg = (k == 4) ? M : Z;
      cyc(1'b0, 1'b1, k == 0, dg);
      total++; if (valid !== (k == 20)) begin bad++; $display("FAIL minus_valid k=%0d: got %b want %b", k, valid, k == 20); end
      if (k == 20) begin
        total++; if (result !== 17'h18000) begin bad++; $display("FAIL minus_result: got %h want 18000", result); end
      end
    end
  endtask

  // en=0 for 3 cycles after index 6. A start driven while en=0 must be ignored.
  task automatic test_en_gap();
    logic       e;
    logic [1:0] dg;
    int         idx;
    for (int k = 0; k < 26; k++) begin
      e   = !(k >= 7 && k <= 9);
      idx = (k <= 6) ? k : k - 3;
      dg  = (!e) ? P : ((idx == 4) ? P : Z);
      cyc(1'b0, e, (k == 0) || (k == 8), dg);
      total++; if (valid !== (k == 23)) begin bad++; $display("FAIL gap_valid k=%0d: got %b want %b", k, valid, k == 23); end
      total++; if (busy !== (k <= 21)) begin bad++; $display("FAIL gap_busy k=%0d: got %b want %b", k, busy, k <= 21); end
      total++; if (result !== ((k >= 23) ? 17'h08000 : 17'h18000)) begin
        bad++; $display("FAIL gap_result k=%0d: got %h want %h", k, result, (k >= 23) ? 17'h08000 : 17'h18000);
      end
    end
  endtask

  // restart at index 10. Only the new frame (index 4 = -1) may report.
  task automatic test_abort();
    logic [1:0] dg;
    for (int k = 0; k < 34; k++) begin
      if (k < 10) dg = (k == 4) ? P : Z;
      else        dg = (k - 10 == 4) ? M : Z;
      cyc(1'b0, 1'b1, (k == 0) || (k == 10), dg);
      total++; if (valid !== (k == 30)) begin bad++; $display("FAIL abort_valid k=%0d: got %b want %b", k, valid, k == 30); end
      total++; if (busy !== (k < 29)) begin bad++; $display("FAIL abort_busy k=%0d: got %b want %b", k, busy, k < 29); end
      if (k >= 30) begin
        total++; if (result !== 17'h18000) begin bad++; $display("FAIL abort_result k=%0d: got %h want 18000", k, result); end
      end
    end
  endtask

  // reset at index 8 clears everything. With no new start, nothing follows.
  task automatic test_reset_mid();
    logic [1:0] dg;
    for (int k = 0; k < 32; k++) begin
      dg = ((k % 4) == 0) ? P : Z;
      cyc(k == 8, 1'b1, k == 0, dg);
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid k=%0d: got %b want 0", k, valid); end
      total++; if (busy !== (k < 8)) begin bad++; $display("FAIL rstmid_busy k=%0d: got %b want %b", k, busy, k < 8); end
      total++; if (result !== ((k < 8) ? 17'h18000 : 17'h00000)) begin
        bad++; $display("FAIL rstmid_result k=%0d: got %h want %h", k, result, (k < 8) ? 17'h18000 : 17'h00000);
      end
    end
  endtask

  // frame A has d=11 at index 6. Frame B starts in A's DONE cycle.
  task automatic test_back_to_back();
    logic [1:0] dg;
    logic       exp_err;
    logic [16:0] exp_res;
    for (int k = 0; k < 45; k++) begin
      if (k < 20) dg = (k == 4) ? P : ((k == 6) ? X : Z);
      else        dg = (k - 20 == 4) ? M : Z;
      cyc(1'b0, 1'b1, (k == 0) || (k == 20), dg);
`ifdef OTF_INVALID_DIGIT_EN
      exp_err = (k >= 6) && (k < 20);
`else
      exp_err = 1'b0;
`endif
      exp_res = (k < 20) ? 17'h00000 : ((k < 40) ? 17'h08000 : 17'h18000);
      total++; if (err !== exp_err) begin bad++; $display("FAIL b2b_err k=%0d: got %b want %b", k, err, exp_err); end
      total++; if (valid !== ((k == 20) || (k == 40))) begin
        bad++; $display("FAIL b2b_valid k=%0d: got %b want %b", k, valid, (k == 20) || (k == 40));
      end
      total++; if (busy !== ((k < 19) || (k >= 20 && k < 39))) begin
        bad++; $display("FAIL b2b_busy k=%0d: got %b want %b", k, busy, (k < 19) || (k >= 20 && k < 39));
      end
      total++; if (result !== exp_res) begin bad++; $display("FAIL b2b_result k=%0d: got %h want %h", k, result, exp_res); end
    end
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    start = 1'b0;
    d_s   = Z;
    test_reset();
    test_plus_one();
    test_half();
    test_minus_one();
    test_en_gap();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
